// File: rtl/forward_ctrl.sv
// Hazard unit for a 5-stage pipeline: selects EX operand bypasses and stalls on load-use.
// Shadow copies of the EX/MEM/WB destination info are kept locally, so they are never read back from the datapath.
module forward_ctrl #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_use_rs_i,
    input  logic          id_use_rt_i,
    input  logic [AW-1:0] id_rd_i,
    input  logic          id_regwrite_i,
    input  logic          id_memread_i,
    input  logic          id_alusrc_i,
    input  logic          flush_i,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o,
    output logic          stall_o,
    output logic [CW-1:0] stall_cnt_o
);

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memread;
        logic [AW-1:0] rd;
    } slot_t;

    localparam logic [1:0]    SEL_RF    = 2'd0;
    localparam logic [1:0]    SEL_EXMEM = 2'd1;
    localparam logic [1:0]    SEL_MEMWB = 2'd2;
    localparam logic [1:0]    SEL_IMM   = 2'd3;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam slot_t         BUBBLE    = '0;

    slot_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;
    logic          advance;

    function automatic logic hit(input slot_t s, input logic [AW-1:0] src);
        return s.valid && s.regwrite && (s.rd == src);
    endfunction

    // Register 0 is hardwired, so it never bypasses; a WB producer is covered
    // by the write-before-read register file and also yields SEL_RF.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [AW-1:0] src,
                                           input slot_t ex, input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = SEL_RF;
        if (use_src && (src != '0)) begin
            if (hit(ex, src))       sel = SEL_EXMEM;
            else if (hit(mem, src)) sel = SEL_MEMWB;
            else if (hit(wb, src))  sel = SEL_RF;
        end
        return sel;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (!rst_i && id_valid_i && !flush_i && ex_q.valid && ex_q.memread &&
            ex_q.regwrite && (ex_q.rd != '0)) begin
            stall = (id_use_rs_i && (id_rs_i == ex_q.rd)) ||
                    (id_use_rt_i && (id_rt_i == ex_q.rd));
        end
    end

    assign advance = id_valid_i && !flush_i && !stall;

    always_comb begin
        wb_d    = mem_q;
        mem_d   = ex_q;
        ex_d    = BUBBLE;
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        cnt_d   = cnt_q;
        if (advance) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            ex_d.rd       = id_rd_i;
            fwd_a_d       = fwd_sel(id_use_rs_i, id_rs_i, ex_q, mem_q, wb_q);
            fwd_b_d       = id_alusrc_i ? SEL_IMM
                                        : fwd_sel(id_use_rt_i, id_rt_i, ex_q, mem_q, wb_q);
        end
        if (stall && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign stall_o     = stall;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl; a second instance with CW=2 checks counter saturation.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld, urs, urt, rw, mr, src, fl;
    logic [4:0] rs, rt, rd;
    logic [1:0] fa, fb, fa2, fb2;
    logic       st, st2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] c16;
        logic [1:0]  c2;
    } exp_t;
    exp_t sb[$];
    logic [15:0] exp_c16 = '0;
    logic [1:0]  exp_c2  = '0;

    always #5 clk = ~clk;

    forward_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs_i(rs), .id_rt_i(rt),
        .id_use_rs_i(urs), .id_use_rt_i(urt), .id_rd_i(rd), .id_regwrite_i(rw),
        .id_memread_i(mr), .id_alusrc_i(src), .flush_i(fl),
        .fwd_a_o(fa), .fwd_b_o(fb), .stall_o(st), .stall_cnt_o(cnt)
    );

    forward_ctrl #(.AW(5), .CW(2)) u_dut_cw2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs_i(rs), .id_rt_i(rt),
        .id_use_rs_i(urs), .id_use_rt_i(urt), .id_rd_i(rd), .id_regwrite_i(rw),
        .id_memread_i(mr), .id_alusrc_i(src), .flush_i(fl),
        .fwd_a_o(fa2), .fwd_b_o(fb2), .stall_o(st2), .stall_cnt_o(cnt2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a_rs, input logic a_urs,
                         input logic [4:0] a_rt, input logic a_urt, input logic [4:0] a_rd,
                         input logic a_rw, input logic a_mr, input logic a_src, input logic a_fl);
        vld = v; rs = a_rs; urs = a_urs; rt = a_rt; urt = a_urt; rd = a_rd;
        rw = a_rw; mr = a_mr; src = a_src; fl = a_fl;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_fwd_a"}, {14'd0, fa}, {14'd0, e.a});
            chk({tag, "_fwd_b"}, {14'd0, fb}, {14'd0, e.b});
            chk({tag, "_cnt"}, cnt, e.c16);
            chk({tag, "_cnt_cw2"}, {14'd0, cnt2}, {14'd0, e.c2});
        end
    endtask

    // One ID-stage cycle: drive, check the combinational stall, then the registered outputs.
    task automatic issue(input string tag, input logic v, input logic [4:0] a_rs, input logic a_urs,
                         input logic [4:0] a_rt, input logic a_urt, input logic [4:0] a_rd,
                         input logic a_rw, input logic a_mr, input logic a_src, input logic a_fl,
                         input logic es, input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        @(negedge clk);
        drive(v, a_rs, a_urs, a_rt, a_urt, a_rd, a_rw, a_mr, a_src, a_fl);
        if (es) begin
            exp_c16 = exp_c16 + 16'd1;
            if (exp_c2 != 2'd3) exp_c2 = exp_c2 + 2'd1;
        end
        e.a = ea; e.b = eb; e.c16 = exp_c16; e.c2 = exp_c2;
        sb.push_back(e);
        #1;
        chk({tag, "_stall"}, {15'd0, st}, {15'd0, es});
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fwd_a", {14'd0, fa}, 16'd0);
        chk("reset_fwd_b", {14'd0, fb}, 16'd0);
        chk("reset_cnt", cnt, 16'd0);
        chk("reset_stall", {15'd0, st}, 16'd0);
        rst = 1'b0;

        //       tag          v     rs urs  rt urt  rd rw mr src fl  stall a  b
        issue("add_r3",     1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        issue("sub_rs_r3",  1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0);
        issue("add_r6",     1, 1, 1, 2, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        issue("nop",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("or_rt_r6",   1, 1, 1, 6, 1, 7, 1, 0, 0, 0, 0, 0, 2);
        issue("and_gap3",   1, 1, 1, 6, 1, 8, 1, 0, 0, 0, 0, 0, 0);
        issue("add_r9a",    1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        issue("add_r9b",    1, 9, 1, 1, 1, 9, 1, 0, 0, 0, 0, 1, 0);
        issue("prio_exmem", 1, 2, 1, 9, 1, 10, 1, 0, 0, 0, 0, 0, 1);
        issue("lw_r5",      1, 1, 1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 3);
        issue("lu_stall",   1, 5, 1, 2, 1, 11, 1, 0, 0, 0, 1, 0, 0);
        issue("lu_resume",  1, 5, 1, 2, 1, 11, 1, 0, 0, 0, 0, 2, 0);
        issue("add_r2",     1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        issue("addi_imm",   1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0, 0, 3);
        issue("add_r0",     1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        issue("lw_r0",      1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 3);
        issue("use_r0",     1, 0, 1, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0);
        issue("lw_r5_b",    1, 1, 1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 3);
        issue("flush_lu",   1, 5, 1, 2, 1, 12, 1, 0, 0, 1, 0, 0, 0);
        issue("after_flush",1, 5, 1, 2, 1, 12, 1, 0, 0, 0, 0, 2, 0);

        // Reset arriving while a load-use stall is pending.
        issue("lw_r5_c",    1, 1, 1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 3);
        @(negedge clk);
        drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midstall_pre", {15'd0, st}, 16'd1);
        rst = 1'b1;
        #1;
        chk("midstall_rst_stall", {15'd0, st}, 16'd0);
        exp_c16 = '0;
        exp_c2  = '0;
        begin
            exp_t e;
            e.a = 2'd0; e.b = 2'd0; e.c16 = 16'd0; e.c2 = 2'd0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        pop_check("midstall_rst");
        rst = 1'b0;
        issue("post_rst",   1, 5, 1, 2, 1, 13, 1, 0, 0, 0, 0, 0, 0);

        // Chained loads, each consumed by the next: four one-cycle stalls.
        issue("chain_lw5",  1, 1, 1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 3);
        for (int k = 0; k < 4; k++) begin
            issue($sformatf("chain_stall%0d", k), 1, 5'(5 + k), 1, 0, 0, 5'(6 + k), 1, 1, 1, 0, 1, 0, 0);
            issue($sformatf("chain_go%0d", k),    1, 5'(5 + k), 1, 0, 0, 5'(6 + k), 1, 1, 1, 0, 0, 2, 3);
        end
        chk("sat_cnt16_final", cnt, 16'd4);
        chk("sat_cnt2_final", {14'd0, cnt2}, 16'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
